m_uart_tx_arb: RTL and testbench
================================

Name: m_uart_tx_arb

Overview:
- Round-robin arbiter that shares one m_uart_tx instance among N_REQ byte producers, such as a debug console, status reporter and loopback echo.
- Each requester offers bytes through a valid/ready handshake. The arbiter captures one byte, issues a one-cycle VALID to the transmitter and waits for its BUSY to fall before granting again.
- Optional message lock: a requester keeps the transmitter until it sends a byte flagged LAST. A timeout frees the lock if the owner stalls.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LOCK_TIMEOUT, 100000, idle cycles before a stalled lock is released; 0 disables the timeout (lock held indefinitely).

Ports:
- CLK  input  1  clock (100 MHz)
- RST_N  input  1  reset, asynchronous, active-low
- REQ_VALID  input  N_REQ  requester i has a byte
- REQ_DATA  input  8*N_REQ  byte of requester i at [8*i+7:8*i]
- REQ_LAST  input  N_REQ  byte i ends its message (releases lock)
- REQ_READY  output  N_REQ  one-hot, one-cycle pulse: byte of requester i captured this cycle
- TX_VALID  output  1  to m_uart_tx VALID
- TX_DIN  output  8  to m_uart_tx DIN
- TX_BUSY  input  1  from m_uart_tx BUSY
- GRANT  output  $clog2(N_REQ)  index of last/current granted requester
- LOCKED  output  1  lock held by GRANT
- ACTIVE  output  1  state != ST_IDLE

Behaviour:
- Reset (RST_N low, async): state ST_IDLE; TX_VALID 0; TX_DIN 8'hFF; REQ_READY 0; GRANT N_REQ-1 (so requester 0 has first priority); LOCKED 0; timeout counter 0.
- Eligible set:
  - Unlocked: all i with REQ_VALID[i].
  - Locked: only GRANT, and only if REQ_VALID[GRANT].
- Round-robin pick: search the eligible set starting at (GRANT+1) mod N_REQ, upward with wrap.
- ST_IDLE, cycle c, if TX_BUSY==0 and the eligible set is non-empty:
  - REQ_READY[g] = 1 combinationally in cycle c; no other READY bit is asserted.
  - TX_DIN <= REQ_DATA[g]; GRANT <= g.
  - LOCKED <= !REQ_LAST[g]; timeout counter <= 0.
  - Next state ST_SEND.
- ST_IDLE with TX_BUSY==1: no grant; stay in ST_IDLE. This covers exit from reset while the transmitter is still sending.
- ST_SEND (cycle c+1): TX_VALID=1 for exactly this cycle; next state ST_WAIT.
- ST_WAIT: TX_VALID=0. Stay while TX_BUSY==1; when TX_BUSY==0, go to ST_IDLE.
  - m_uart_tx raises BUSY the cycle after VALID, so ST_WAIT is always entered with BUSY high.
- Byte cadence:
  - Grant-to-grant minimum = 3 + 10*WAIT_DIV cycles for the transmitter.
  - REQ_DATA is sampled only in the READY cycle and may change afterwards.
- Lock timeout:
  - The counter increments in ST_IDLE each cycle LOCKED==1 && !REQ_VALID[GRANT] && LOCKED_TIMEOUT!=0.
  - When the counter == LOCK_TIMEOUT-1 (the timeout-th stalled cycle), LOCKED <= 0 and the counter <= 0.
  - The counter holds its value when the owner is valid.
- Locked with other requesters valid: they wait; no READY is issued to them.
- Simultaneous events:
  - Owner REQ_VALID rising in the same cycle the timeout expires: the owner is still eligible and the grant wins; the timeout is discarded.
  - All N_REQ valid: grants rotate 0,1,2,3,0,... when each byte is LAST.
- Widths:
  - GRANT wraps modulo N_REQ.
  - Timeout counter is $clog2(LOCK_TIMEOUT+1) bits.
- Reset mid-operation: outputs return to reset values immediately. The transmitter, if not reset, finishes its frame; the arbiter waits in ST_IDLE for TX_BUSY low.

Decomposition:
- Package m_uart_pkg holds:
  - typedef enum {ST_IDLE, ST_SEND, ST_WAIT} arb_state_t;
  - localparam UART_FRAME_BITS = 10.
- Sub-module m_rr_pick (combinational): inputs request vector and start index; outputs found flag and index. Parameterised by N_REQ.

Test Plan:
Use N_REQ=4, LOCK_TIMEOUT=50, and m_uart_tx with WAIT_DIV=4 (40 cycles/frame).
- Single byte: REQ_VALID=4'b0001, DATA0=8'hA5, LAST0=1 -> READY[0] pulses 1 cycle; TX_VALID 1 cycle later; DOUT frame 0,1,0,1,0,0,1,0,1,1; LOCKED stays 0.
- Fairness: all four valid with LAST=1, data 8'h10..8'h13 -> TX_DIN order 10,11,12,13,10; READY always one-hot; grant-to-grant spacing = 43 cycles.
- Lock: req1 sends 3 bytes, LAST only on the third, while req2 is continuously valid -> TX_DIN sequence is the three req1 bytes, then the req2 byte; LOCKED=1 between the first and third byte.
- Timeout: req1 sends a byte with LAST=0, then drops VALID, with req3 valid -> LOCKED falls exactly 50 ST_IDLE cycles after ST_WAIT exits; req3 is granted the next cycle.
- Busy guard: hold TX_BUSY=1 externally with req0 valid -> no READY, no TX_VALID; release -> grant in the first cycle TX_BUSY==0.
- Reset mid-frame: assert RST_N low during ST_WAIT (arbiter only) -> TX_VALID=0, READY=0, GRANT=3 immediately; after release, no grant until TX_BUSY falls.

Source files
------------

// File: rtl/m_uart_tx_arb_pkg.sv
// Shared types for the UART transmit arbiter.
// State encoding, frame length and counter sizing helper.
package m_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  localparam int UART_FRAME_BITS = 10;

  // Width of a counter that must reach `timeout`, never zero bits.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/m_uart_tx_arb_if.sv
// Requester and transmitter bundle of the UART arbiter.
// slave = arbiter side, master = requesters plus transmitter.
interface m_uart_tx_arb_if #(
  parameter int N_REQ = 4
);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]   REQ_VALID;
  logic [8*N_REQ-1:0] REQ_DATA;
  logic [N_REQ-1:0]   REQ_LAST;
  logic [N_REQ-1:0]   REQ_READY;
  logic               TX_VALID;
  logic [7:0]         TX_DIN;
  logic               TX_BUSY;
  logic [GW-1:0]      GRANT;
  logic               LOCKED;
  logic               ACTIVE;

  modport slave (
    input  REQ_VALID, REQ_DATA, REQ_LAST, TX_BUSY,
    output REQ_READY, TX_VALID, TX_DIN,
    output GRANT, LOCKED, ACTIVE
  );

  modport master (
    output REQ_VALID, REQ_DATA, REQ_LAST, TX_BUSY,
    input  REQ_READY, TX_VALID, TX_DIN,
    input  GRANT, LOCKED, ACTIVE
  );

endinterface

// File: rtl/m_uart_tx_arb_rr_pick.sv
// Round-robin search: first set request at or after start_i,
// wrapping modulo N_REQ.
module m_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int GW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [GW-1:0]    start_i,
  output logic             found_o,
  output logic [GW-1:0]    idx_o
);

  int          j;
  logic [GW-1:0] jj;

  // Scan farthest-first so the nearest hit is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    jj      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(start_i) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = GW'(j);
      if (req_i[jj]) begin
        found_o = 1'b1;
        idx_o   = jj;
      end
    end
  end

endmodule

// File: rtl/m_uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between
// N_REQ byte producers, with optional message lock and timeout.
module m_uart_tx_arb
  import m_uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int LOCK_TIMEOUT = 100000
) (
  input  logic             CLK,
  input  logic             RST_N,
  m_uart_tx_arb_if.slave   io
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = cnt_width(LOCK_TIMEOUT);
  localparam logic [GW-1:0] LAST_IDX = GW'(N_REQ - 1);
  localparam logic [CW-1:0] TO_MAX =
    CW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam bit TO_EN = (LOCK_TIMEOUT != 0);

  arb_state_t state_q, state_d;

  logic [GW-1:0]    grant_q, grant_d;
  logic             locked_q, locked_d;
  logic [7:0]       din_q, din_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N_REQ-1:0] own;
  logic [N_REQ-1:0] elig;
  logic [GW-1:0]    start;
  logic [GW-1:0]    pick;
  logic             found;
  logic             fire;
  logic             stall;

  // Eligible set and search origin one past the last grant.
  always_comb begin
    own        = '0;
    own[grant_q] = 1'b1;
    elig  = locked_q ? (io.REQ_VALID & own) : io.REQ_VALID;
    start = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
  end

  m_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i   (elig),
    .start_i (start),
    .found_o (found),
    .idx_o   (pick)
  );

  // Grant only from idle with the transmitter free; a stall is an
  // idle cycle where the lock owner has nothing to offer.
  always_comb begin
    fire  = (state_q == ST_IDLE) && !io.TX_BUSY && found;
    stall = (state_q == ST_IDLE) && locked_q && TO_EN &&
            !io.REQ_VALID[grant_q];
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: idle -> send (one cycle) -> wait for busy to drop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (fire) state_d = ST_SEND;
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: if (!io.TX_BUSY) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: combinational ready pulse, registered byte and status.
  always_comb begin
    io.REQ_READY = fire ? (N_REQ'(1) << pick) : '0;
    io.TX_VALID  = (state_q == ST_SEND);
    io.ACTIVE    = (state_q != ST_IDLE);
    io.TX_DIN    = din_q;
    io.GRANT     = grant_q;
    io.LOCKED    = locked_q;
  end

  // Capture on grant; otherwise age a stalled lock until it expires.
  // A grant and a stall cannot coincide, so the grant always wins.
  always_comb begin
    grant_d  = grant_q;
    locked_d = locked_q;
    din_d    = din_q;
    cnt_d    = cnt_q;
    if (fire) begin
      grant_d  = pick;
      din_d    = io.REQ_DATA[8*int'(pick) +: 8];
      locked_d = !io.REQ_LAST[pick];
      cnt_d    = '0;
    end else if (stall) begin
      if (cnt_q == TO_MAX) begin
        locked_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant_q  <= LAST_IDX;
      locked_q <= 1'b0;
      din_q    <= 8'hFF;
      cnt_q    <= '0;
    end else begin
      grant_q  <= grant_d;
      locked_q <= locked_d;
      din_q    <= din_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_m_uart_tx_arb.sv
// Self-checking bench for m_uart_tx_arb with a behavioural
// transmitter (busy for one frame after each VALID).
module tb_m_uart_tx_arb;
  import m_uart_pkg::*;

  localparam int N        = 4;
  localparam int TO       = 50;
  localparam int WAIT_DIV = 4;
  localparam int FRAME    = UART_FRAME_BITS * WAIT_DIV;
  localparam int GAP      = 3 + FRAME;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  m_uart_tx_arb_if #(.N_REQ(N)) bus();

  m_uart_tx_arb #(
    .N_REQ        (N),
    .LOCK_TIMEOUT (TO)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .io    (bus)
  );

  // Transmitter model, not reset with the arbiter.
  int   busy_cnt = 0;
  logic ext_busy = 1'b0;
  always @(posedge clk) begin
    if (bus.TX_VALID) busy_cnt <= FRAME;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.TX_BUSY = (busy_cnt != 0) || ext_busy;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    logic [1:0] exp_grant;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d);
    bus.REQ_VALID = v;
    bus.REQ_LAST  = l;
    bus.REQ_DATA  = d;
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_ready(output int idx, input int lim);
    idx = -1;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk); #1;
      if (bus.REQ_READY != 0) begin
        check("ready_onehot", 32'($onehot(bus.REQ_READY)), 1);
        idx = oh2i(bus.REQ_READY);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int lim);
    for (int k = 0; k < lim; k++) begin
      if (!bus.ACTIVE) break;
      @(posedge clk); #1;
    end
    if (bus.ACTIVE) check("idle_wait_expired", 1, 0);
  endtask

  task automatic do_reset;
    drive(4'h0, 4'h0, 32'h0);
    ext_busy = 1'b0;
    for (int k = 0; k < 200 && bus.TX_BUSY; k++) @(posedge clk);
    if (bus.TX_BUSY) check("busy_drain_expired", 1, 0);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int   idx;
    int   t[5];
    int   g[5];
    int   idle_n;
    int   viol;
    bit   done;
    int   m_gr;
    bit   m_lk;
    logic [7:0] m_din;
    int   m_since;
    int   m_to;
    logic [3:0] quiet;
    logic [3:0] v, l, el, er;
    logic [31:0] d;
    int   j;
    bit   avail;

    drive(4'h0, 4'h0, 32'h0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  32'(bus.REQ_READY), 0);
    check("rst_txv",    32'(bus.TX_VALID), 0);
    check("rst_din",    32'(bus.TX_DIN), 32'hFF);
    check("rst_grant",  32'(bus.GRANT), 3);
    check("rst_locked", 32'(bus.LOCKED), 0);
    check("rst_active", 32'(bus.ACTIVE), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Round-robin picks starting from the reset grant of 3.
    tbl[0] = '{4'b1111, 4'b0001, 2'd0};
    tbl[1] = '{4'b1111, 4'b0010, 2'd1};
    tbl[2] = '{4'b1001, 4'b1000, 2'd3};
    tbl[3] = '{4'b0110, 4'b0010, 2'd1};
    tbl[4] = '{4'b0001, 4'b0001, 2'd0};
    tbl[5] = '{4'b0000, 4'b0000, 2'd0};
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].valid, 4'hF, 32'h13121110);
      @(negedge clk); #1;
      check("tbl_ready", 32'(bus.REQ_READY), 32'(tbl[i].exp_ready));
      @(posedge clk); #1;
      drive(4'h0, 4'h0, 32'h0);
      check("tbl_grant", 32'(bus.GRANT), 32'(tbl[i].exp_grant));
      if (tbl[i].exp_ready != 0) begin
        check("tbl_din", 32'(bus.TX_DIN),
              32'(8'h10) + 32'(tbl[i].exp_grant));
        wait_idle(100);
      end
    end

    // Single byte.
    do_reset();
    drive(4'b0001, 4'b0001, 32'h000000A5);
    wait_ready(idx, 10);
    check("sb_idx", 32'(idx), 0);
    drive(4'h0, 4'h0, 32'h0);
    check("sb_txv", 32'(bus.TX_VALID), 1);
    check("sb_din", 32'(bus.TX_DIN), 32'hA5);
    check("sb_locked", 32'(bus.LOCKED), 0);
    @(posedge clk); #1;
    check("sb_txv_drop", 32'(bus.TX_VALID), 0);
    wait_idle(100);

    // Fairness and cadence.
    do_reset();
    drive(4'hF, 4'hF, 32'h13121110);
    for (int k = 0; k < 5; k++) begin
      wait_ready(g[k], 100);
      t[k] = cyc;
      check("fair_idx", 32'(g[k]), 32'(k % 4));
      check("fair_din", 32'(bus.TX_DIN), 32'(8'h10 + k % 4));
      if (k > 0) check("fair_gap", 32'(t[k] - t[k-1]), GAP);
    end
    drive(4'h0, 4'h0, 32'h0);
    wait_idle(100);

    // Message lock holds off a valid competitor.
    do_reset();
    drive(4'b0110, 4'b0100, 32'h00C2B100);
    wait_ready(idx, 10);
    check("lk_idx0", 32'(idx), 1);
    check("lk_din0", 32'(bus.TX_DIN), 32'hB1);
    check("lk_lock0", 32'(bus.LOCKED), 1);
    drive(4'b0110, 4'b0100, 32'h00C2B200);
    wait_ready(idx, 100);
    check("lk_idx1", 32'(idx), 1);
    check("lk_din1", 32'(bus.TX_DIN), 32'hB2);
    check("lk_lock1", 32'(bus.LOCKED), 1);
    drive(4'b0110, 4'b0110, 32'h00C2B300);
    wait_ready(idx, 100);
    check("lk_idx2", 32'(idx), 1);
    check("lk_din2", 32'(bus.TX_DIN), 32'hB3);
    check("lk_lock2", 32'(bus.LOCKED), 0);
    drive(4'b0100, 4'b0100, 32'h00C2B300);
    wait_ready(idx, 100);
    check("lk_idx3", 32'(idx), 2);
    check("lk_din3", 32'(bus.TX_DIN), 32'hC2);
    drive(4'h0, 4'h0, 32'h0);
    wait_idle(100);

    // Timeout releases a stalled lock; req3 granted at once.
    do_reset();
    drive(4'b1010, 4'b0000, 32'hD300A100);
    wait_ready(idx, 10);
    check("to_idx", 32'(idx), 1);
    check("to_locked", 32'(bus.LOCKED), 1);
    drive(4'b1000, 4'b0000, 32'hD300A100);
    idle_n = 0;
    done   = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); #1;
      if (!bus.ACTIVE && bus.LOCKED) begin
        idle_n++;
        if (bus.REQ_READY != 0) viol++;
      end else if (!bus.LOCKED) begin
        check("to_ready", 32'(bus.REQ_READY), 32'b1000);
        done = 1'b1;
        break;
      end
    end
    check("to_cycles", 32'(idle_n), TO);
    if (!done) check("to_expired", 1, 0);
    @(posedge clk); #1;
    check("to_grant", 32'(bus.GRANT), 3);
    check("to_din", 32'(bus.TX_DIN), 32'hD3);
    drive(4'h0, 4'h0, 32'h0);
    wait_idle(100);

    // Owner returns on the very cycle the timeout would fire.
    do_reset();
    drive(4'b0010, 4'b0000, 32'h0000A100);
    wait_ready(idx, 10);
    check("sim_idx", 32'(idx), 1);
    drive(4'b1000, 4'b0000, 32'h00000000);
    idle_n = 0;
    done   = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); #1;
      if (!bus.ACTIVE) begin
        idle_n++;
        if (idle_n == TO) begin
          drive(4'b1010, 4'b0000, 32'h0000A200);
          #1;
          check("sim_ready", 32'(bus.REQ_READY), 32'b0010);
          done = 1'b1;
          break;
        end
      end
    end
    if (!done) check("sim_expired", 1, 0);
    @(posedge clk); #1;
    drive(4'h0, 4'h0, 32'h0);
    check("sim_grant", 32'(bus.GRANT), 1);
    check("sim_locked", 32'(bus.LOCKED), 1);
    check("sim_din", 32'(bus.TX_DIN), 32'hA2);
    wait_idle(100);

    // Busy guard.
    do_reset();
    ext_busy = 1'b1;
    drive(4'b0001, 4'b0001, 32'h0000005A);
    viol = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (bus.REQ_READY != 0 || bus.TX_VALID) viol++;
    end
    check("bg_quiet", 32'(viol), 0);
    @(posedge clk); #1;
    ext_busy = 1'b0;
    @(negedge clk); #1;
    check("bg_ready", 32'(bus.REQ_READY), 1);
    @(posedge clk); #1;
    drive(4'h0, 4'h0, 32'h0);
    wait_idle(100);

    // Reset during the wait phase of a frame.
    do_reset();
    drive(4'b0001, 4'b0001, 32'h00000077);
    wait_ready(idx, 10);
    check("rmf_idx", 32'(idx), 0);
    drive(4'h0, 4'h0, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    check("rmf_active", 32'(bus.ACTIVE), 1);
    drive(4'b0001, 4'b0001, 32'h00000078);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("rmf_txv", 32'(bus.TX_VALID), 0);
    check("rmf_rdy", 32'(bus.REQ_READY), 0);
    check("rmf_grant", 32'(bus.GRANT), 3);
    check("rmf_act", 32'(bus.ACTIVE), 0);
    check("rmf_din", 32'(bus.TX_DIN), 32'hFF);
    @(negedge clk) rst_n = 1'b1;
    viol = 0;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (bus.TX_BUSY) begin
        if (bus.REQ_READY != 0) viol++;
      end else begin
        check("rmf_first_ready", 32'(bus.REQ_READY), 1);
        done = 1'b1;
        break;
      end
    end
    check("rmf_no_early", 32'(viol), 0);
    if (!done) check("rmf_expired", 1, 0);
    @(posedge clk); #1;
    drive(4'h0, 4'h0, 32'h0);
    wait_idle(100);

    // Random traffic against a transaction-level model.
    do_reset();
    m_gr    = N - 1;
    m_lk    = 1'b0;
    m_din   = 8'hFF;
    m_since = 1000;
    m_to    = 0;
    for (int blk = 0; blk < 15; blk++) begin
      quiet = 4'($urandom_range(0, 15));
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
          v[i] = ($urandom_range(0, 99) < 30) && !quiet[i];
          l[i] = 1'($urandom_range(0, 1));
        end
        d = $urandom;
        drive(v, l, d);
        #1;
        avail = (m_since >= GAP);
        el = m_lk ? (v & (4'b0001 << m_gr)) : v;
        er = 4'h0;
        j  = -1;
        if (avail) begin
          for (int k = 1; k <= N; k++) begin
            if (j < 0 && el[(m_gr + k) % N]) j = (m_gr + k) % N;
          end
        end
        if (j >= 0) er = 4'b0001 << j;
        check("rand_cycle",
          32'({bus.REQ_READY, bus.TX_VALID, bus.TX_DIN,
               bus.GRANT, bus.LOCKED, bus.ACTIVE}),
          32'({er, (m_since == 1), m_din,
               2'(m_gr), m_lk, (m_since < GAP)}));
        if (j >= 0) begin
          m_gr    = j;
          m_lk    = !l[j];
          m_din   = d[8*j +: 8];
          m_to    = 0;
          m_since = 1;
        end else begin
          if (avail && m_lk && !v[m_gr]) begin
            m_to++;
            if (m_to == TO) begin
              m_lk = 1'b0;
              m_to = 0;
            end
          end
          if (m_since < 1000) m_since++;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
